// File: rtl/param_basic_datapath.sv
// param_basic_datapath
//   Parameterised basic-computer datapath: AR, PC, DR, AC, IR, TR, E, a
//   3-bit-select common bus, an accumulator ALU, on-chip memory with a
//   multi-cycle read handshake, and INPR/OUTR character I/O with flags.
// Ports
//   clk, reset          clock, synchronous active-high reset
//   bus_sel, ld, inc,   per-cycle register-transfer controls from the
//   clr, alu_op,        control unit
//   e_clr, e_cmp
//   mem_rd, mem_wr      memory read start (at AR) / write bus to mem[AR]
//   mem_busy,           read in flight / 1-cycle read-latch-updated pulse
//   mem_rd_valid
//   in_*, fgi_clr, fgi  input character handshake and flag
//   out_*, fgo          output character handshake and flag
//   ar..tr, e, n, z,    register contents and status for the sequencer
//   bus
module param_basic_datapath #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1,
  parameter int IO_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        bus_sel,
  input  logic [6:0]        ld,
  input  logic [5:0]        inc,
  input  logic [5:0]        clr,
  input  logic [2:0]        alu_op,
  input  logic              e_clr,
  input  logic              e_cmp,
  input  logic              mem_rd,
  input  logic              mem_wr,
  output logic              mem_busy,
  output logic              mem_rd_valid,
  input  logic [IO_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              fgi_clr,
  output logic [IO_W-1:0]   out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              fgi,
  output logic              fgo,
  output logic [ADDR_W-1:0] ar,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] dr,
  output logic [DATA_W-1:0] ac,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] tr,
  output logic              e,
  output logic              n,
  output logic              z,
  output logic [DATA_W-1:0] bus
);

  localparam logic [DATA_W-1:0] IO_MASK = DATA_W'({IO_W{1'b1}});

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_snap;   // mem[AR] captured at read acceptance
  logic [DATA_W-1:0] rd_latch;
  logic [1:0]        rd_cnt;
  logic [IO_W-1:0]   inpr;
  logic [DATA_W-1:0] alu_res;
  logic              alu_e;
  logic              alu_e_upd;
  logic              rd_go;
  logic              wr_go;

  always_comb begin
    bus = '0;
    case (bus_sel)
      3'd1: bus = DATA_W'(ar);
      3'd2: bus = DATA_W'(pc);
      3'd3: bus = dr;
      3'd4: bus = ac;
      3'd5: bus = ir;
      3'd6: bus = tr;
      3'd7: bus = rd_latch;
      default: bus = '0;
    endcase
  end

  // E follows the ALU only for ADD/CIR/CIL and only when AC actually
  // takes the ALU result.
  always_comb begin
    alu_res   = ac;
    alu_e     = e;
    alu_e_upd = 1'b0;
    case (alu_op)
      3'd0: alu_res = ac & dr;
      3'd1: begin
        {alu_e, alu_res} = {1'b0, ac} + {1'b0, dr};
        alu_e_upd = 1'b1;
      end
      3'd2: alu_res = dr;
      3'd3: alu_res = ~ac;
      3'd4: begin
        alu_res   = {e, ac[DATA_W-1:1]};
        alu_e     = ac[0];
        alu_e_upd = 1'b1;
      end
      3'd5: begin
        alu_res   = {ac[DATA_W-2:0], e};
        alu_e     = ac[DATA_W-1];
        alu_e_upd = 1'b1;
      end
      3'd6: alu_res = (ac & ~IO_MASK) | DATA_W'(inpr);
      default: alu_res = ac;
    endcase
  end

  // A coincident write wins over a read; both are refused while busy.
  assign wr_go = mem_wr & ~mem_busy;
  assign rd_go = mem_rd & ~mem_wr & ~mem_busy;

  // Read data is snapshotted at acceptance so later writes to the same
  // address during the busy window cannot leak into the result.
  always_ff @(posedge clk) begin
    if (wr_go) mem[ar] <= bus;
    if (rd_go) rd_snap <= mem[ar];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ar <= '0; pc <= '0; dr <= '0; ac <= '0; ir <= '0; tr <= '0;
      e <= 1'b0; inpr <= '0; out_data <= '0; out_valid <= 1'b0;
      fgi <= 1'b0; rd_latch <= '0; rd_cnt <= '0;
      mem_busy <= 1'b0; mem_rd_valid <= 1'b0;
    end else begin
      if (clr[0])      ar <= '0;
      else if (ld[0])  ar <= bus[ADDR_W-1:0];
      else if (inc[0]) ar <= ar + ADDR_W'(1);

      if (clr[1])      pc <= '0;
      else if (ld[1])  pc <= bus[ADDR_W-1:0];
      else if (inc[1]) pc <= pc + ADDR_W'(1);

      if (clr[2])      dr <= '0;
      else if (ld[2])  dr <= bus;
      else if (inc[2]) dr <= dr + DATA_W'(1);

      if (clr[3])      ac <= '0;
      else if (ld[3])  ac <= alu_res;
      else if (inc[3]) ac <= ac + DATA_W'(1);

      if (clr[4])      ir <= '0;
      else if (ld[4])  ir <= bus;
      else if (inc[4]) ir <= ir + DATA_W'(1);

      if (clr[5])      tr <= '0;
      else if (ld[5])  tr <= bus;
      else if (inc[5]) tr <= tr + DATA_W'(1);

      if (e_clr)                            e <= 1'b0;
      else if (e_cmp)                       e <= ~e;
      else if (ld[3] && !clr[3] && alu_e_upd) e <= alu_e;

      // Capture beats a same-cycle fgi_clr.
      if (in_valid && !fgi) begin
        inpr <= in_data;
        fgi  <= 1'b1;
      end else if (fgi_clr) begin
        fgi <= 1'b0;
      end

      // A handshake frees OUTR in the same cycle a new load may refill it.
      if (ld[6] && (!out_valid || out_ready)) begin
        out_data  <= bus[IO_W-1:0];
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      mem_rd_valid <= 1'b0;
      if (rd_go) begin
        mem_busy <= 1'b1;
        rd_cnt   <= 2'(RD_LAT - 1);
      end else if (mem_busy) begin
        if (rd_cnt == 2'd0) begin
          mem_busy     <= 1'b0;
          mem_rd_valid <= 1'b1;
          rd_latch     <= rd_snap;
        end else begin
          rd_cnt <= rd_cnt - 2'd1;
        end
      end
    end
  end

  assign in_ready = ~fgi;
  assign fgo      = ~out_valid;
  assign n        = ac[DATA_W-1];
  assign z        = (ac == '0);

endmodule

// File: tb/tb_param_basic_datapath.sv
module tb_param_basic_datapath;
  localparam int DATA_W = 16, ADDR_W = 12, RD_LAT = 3, IO_W = 8;

  logic clk = 1'b0, reset;
  logic [2:0] bus_sel, alu_op;
  logic [6:0] ld;
  logic [5:0] inc, clr;
  logic e_clr, e_cmp, mem_rd, mem_wr, mem_busy, mem_rd_valid;
  logic [IO_W-1:0] in_data, out_data;
  logic in_valid, in_ready, fgi_clr, out_valid, out_ready, fgi, fgo;
  logic [ADDR_W-1:0] ar, pc;
  logic [DATA_W-1:0] dr, ac, ir, tr, bus;
  logic e, n, z;

  int vectors = 0, miscompares = 0;
  logic [DATA_W-1:0] sb_q[$];

  param_basic_datapath #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .IO_W(IO_W)) dut (
    .clk(clk), .reset(reset), .bus_sel(bus_sel), .ld(ld), .inc(inc), .clr(clr),
    .alu_op(alu_op), .e_clr(e_clr), .e_cmp(e_cmp), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_busy(mem_busy), .mem_rd_valid(mem_rd_valid), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .fgi_clr(fgi_clr), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .fgi(fgi), .fgo(fgo), .ar(ar), .pc(pc),
    .dr(dr), .ac(ac), .ir(ir), .tr(tr), .e(e), .n(n), .z(z), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put_char(input logic [7:0] c);
    in_data = c; in_valid = 1'b1; step(); in_valid = 1'b0;
    chk("fgi_set", fgi, 1); chk("in_ready_low", in_ready, 0);
    alu_op = 3'd6; ld = 7'h08; step(); ld = '0;
    fgi_clr = 1'b1; step(); fgi_clr = 1'b0;
    chk("fgi_clr", fgi, 0);
  endtask

  // Builds an AC value from two INP characters with eight CILs between.
  task automatic set_ac(input logic [15:0] v);
    clr = 6'h08; step(); clr = '0;
    e_clr = 1'b1; step(); e_clr = 1'b0;
    put_char(v[15:8]);
    alu_op = 3'd5; ld = 7'h08; repeat (8) step(); ld = '0;
    put_char(v[7:0]);
    chk("set_ac", ac, v);
  endtask

  task automatic wait_read(input string tag, input int exp_busy);
    int cyc = 0, nb = 0;
    logic [DATA_W-1:0] exp;
    bus_sel = 3'd7;
    while (!mem_rd_valid && cyc < 20) begin
      if (mem_busy) nb++;
      step(); cyc++;
    end
    chk({tag, "_valid"}, mem_rd_valid, 1);
    chk({tag, "_busy_cycles"}, nb, exp_busy);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hDEAD;
    chk({tag, "_data"}, bus, exp);
    step();
    chk({tag, "_pulse_1cyc"}, mem_rd_valid, 0);
    chk({tag, "_latch_hold"}, bus, exp);
  endtask

  task automatic issue_read(input logic [DATA_W-1:0] exp);
    mem_rd = 1'b1; bus_sel = 3'd7; sb_q.push_back(exp);
    step(); mem_rd = 1'b0;
  endtask

  initial begin
    bit saw;
    reset = 1'b1; bus_sel = '0; ld = '0; inc = '0; clr = '0; alu_op = '0;
    e_clr = 0; e_cmp = 0; mem_rd = 0; mem_wr = 0; in_data = '0; in_valid = 0;
    fgi_clr = 0; out_ready = 0;
    step(); step(); reset = 1'b0;

    chk("rst_ar", ar, 0); chk("rst_pc", pc, 0); chk("rst_dr", dr, 0);
    chk("rst_ac", ac, 0); chk("rst_ir", ir, 0); chk("rst_tr", tr, 0);
    chk("rst_e", e, 0); chk("rst_fgo", fgo, 1); chk("rst_fgi", fgi, 0);
    chk("rst_in_ready", in_ready, 1); chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", mem_busy, 0); chk("rst_valid", mem_rd_valid, 0); chk("rst_z", z, 1);

    // Fetch with PC wrap
    set_ac(16'h0FFF);
    bus_sel = 3'd4; ld = 7'h02; step();
    chk("pc_load", pc, 12'hFFF);
    bus_sel = 3'd2; ld = 7'h01; inc = 6'h02; step(); ld = '0; inc = '0;
    chk("fetch_ar", ar, 12'hFFF); chk("fetch_pc_wrap", pc, 12'h000);

    // Priority: ld over inc, clr over ld
    bus_sel = 3'd4; ld = 7'h02; inc = 6'h02; step();
    chk("ld_over_inc", pc, 12'hFFF);
    clr = 6'h02; step(); ld = '0; inc = '0; clr = '0;
    chk("clr_over_ld", pc, 12'h000);

    // Memory write then read with RD_LAT=3
    set_ac(16'h0005);
    bus_sel = 3'd4; ld = 7'h01; step(); ld = '0;
    chk("ar_5", ar, 12'h005);
    set_ac(16'h1234);
    bus_sel = 3'd4; mem_wr = 1'b1; step(); mem_wr = 1'b0;
    issue_read(16'h1234);
    chk("busy_after_accept", mem_busy, 1);
    wait_read("rd1", RD_LAT);

    // Write to same address during busy is ignored; read gets old data
    set_ac(16'hBEEF);
    issue_read(16'h1234);
    bus_sel = 3'd4; mem_wr = 1'b1; step(); mem_wr = 1'b0;
    wait_read("rd_wr_busy", RD_LAT - 1);
    issue_read(16'h1234);
    wait_read("rd_after_ign", RD_LAT);

    // ADD with carry, then CIL, then CIR
    set_ac(16'hFFFF);
    chk("n_flag", n, 1);
    clr = 6'h04; step(); clr = '0;
    inc = 6'h04; step(); inc = '0;
    chk("dr_1", dr, 16'h0001);
    alu_op = 3'd1; ld = 7'h08; step();
    chk("add_ac", ac, 16'h0000); chk("add_e", e, 1); chk("add_z", z, 1);
    alu_op = 3'd5; step();
    chk("cil_ac", ac, 16'h0001); chk("cil_e", e, 0);
    alu_op = 3'd4; step(); ld = '0;
    chk("cir_ac", ac, 16'h0000); chk("cir_e", e, 1);
    e_clr = 1'b1; e_cmp = 1'b1; step(); e_clr = 0; e_cmp = 0;
    chk("eclr_wins", e, 0);

    // Capture beats fgi_clr
    in_data = 8'h41; in_valid = 1'b1; fgi_clr = 1'b1; step();
    in_valid = 1'b0; fgi_clr = 1'b0;
    chk("cap_beats_clr", fgi, 1);
    alu_op = 3'd6; ld = 7'h08; step(); ld = '0;
    chk("inp_ac", ac, 16'h0041);
    fgi_clr = 1'b1; step(); fgi_clr = 1'b0;
    chk("fgi_cleared", fgi, 0);

    // OUTR hold, ignore, simultaneous handshake+load, drain
    out_ready = 1'b0; bus_sel = 3'd4; ld = 7'h40; step();
    chk("outr_load", out_data, 8'h41); chk("out_valid", out_valid, 1); chk("fgo_low", fgo, 0);
    bus_sel = 3'd0; step();
    chk("outr_ignored", out_data, 8'h41);
    out_ready = 1'b1; step(); ld = '0;
    chk("outr_reload", out_data, 8'h00); chk("out_valid_kept", out_valid, 1);
    step(); out_ready = 1'b0;
    chk("out_drained", out_valid, 0); chk("fgo_high", fgo, 1);

    // mem_rd + mem_wr together: write only
    set_ac(16'h00A5);
    bus_sel = 3'd4; mem_rd = 1'b1; mem_wr = 1'b1; step(); mem_rd = 0; mem_wr = 0;
    chk("rdwr_no_busy", mem_busy, 0);
    issue_read(16'h00A5);
    wait_read("rd_wronly", RD_LAT);

    // Reset mid-read cancels it
    mem_rd = 1'b1; step(); mem_rd = 1'b0; step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("midrst_busy", mem_busy, 0); chk("midrst_valid", mem_rd_valid, 0);
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin step(); if (mem_rd_valid) saw = 1'b1; end
    chk("midrst_no_pulse", saw, 0);
    bus_sel = 3'd7; #1;
    chk("midrst_latch", bus, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
